// File: rtl/mem_arbiter_pkg.sv
// Shared memory-map constants and arbiter state/grant encodings.
// Imported by the arbiter and by anything that needs the peripheral addresses.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;

  localparam logic [31:0] MM_UART_DATA_ADDR = 32'hBFD003F8;
  localparam logic [31:0] MM_UART_STAT_ADDR = 32'hBFD003FC;
  localparam logic [31:0] MM_LED_ADDR       = 32'hBFD00400;
  localparam logic [31:0] MM_DPY_ADDR       = 32'hBFD00408;

  localparam int unsigned MM_UART_GAP = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port has priority over instruction fetch,
// one access per IDLE/ACC/DONE round, with an idle gap after each UART data write.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] UART_DATA_ADDR = MM_UART_DATA_ADDR,
  parameter int unsigned UART_GAP       = MM_UART_GAP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_byte,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_byte,
  input  logic [31:0] mmu_rdata
);

  localparam int CNT_W = $clog2(UART_GAP) + 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (UART_GAP == 0) ? '0 : CNT_W'(UART_GAP - 1);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              uart_wr_q, uart_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mmu_read_q, mmu_read_d;
  logic              mmu_write_q, mmu_write_d;
  logic [31:0]       mmu_addr_q, mmu_addr_d;
  logic [31:0]       mmu_wdata_q, mmu_wdata_d;
  logic              mmu_byte_q, mmu_byte_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      uart_wr_q   <= 1'b0;
      cnt_q       <= '0;
      mmu_read_q  <= 1'b0;
      mmu_write_q <= 1'b0;
      mmu_addr_q  <= '0;
      mmu_wdata_q <= '0;
      mmu_byte_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      uart_wr_q   <= uart_wr_d;
      cnt_q       <= cnt_d;
      mmu_read_q  <= mmu_read_d;
      mmu_write_q <= mmu_write_d;
      mmu_addr_q  <= mmu_addr_d;
      mmu_wdata_q <= mmu_wdata_d;
      mmu_byte_q  <= mmu_byte_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    uart_wr_d   = uart_wr_q;
    cnt_d       = cnt_q;
    mmu_read_d  = mmu_read_q;
    mmu_write_d = mmu_write_q;
    mmu_addr_d  = mmu_addr_q;
    mmu_wdata_d = mmu_wdata_q;
    mmu_byte_d  = mmu_byte_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // A read+write request collapses to a read, so write is only taken when rd is low.
        if (mem_rd || mem_wr) begin
          state_d     = ST_ACC;
          grant_d     = GNT_MEM;
          mmu_read_d  = mem_rd;
          mmu_write_d = mem_wr & ~mem_rd;
          mmu_addr_d  = mem_addr;
          mmu_wdata_d = mem_wdata;
          mmu_byte_d  = mem_byte;
          uart_wr_d   = mem_wr & ~mem_rd & (mem_addr == UART_DATA_ADDR);
        end else if (if_req) begin
          state_d     = ST_ACC;
          grant_d     = GNT_IF;
          mmu_read_d  = 1'b1;
          mmu_write_d = 1'b0;
          mmu_addr_d  = if_addr;
          mmu_wdata_d = '0;
          mmu_byte_d  = 1'b0;
          uart_wr_d   = 1'b0;
        end
      end
      ST_ACC: begin
        state_d     = ST_DONE;
        mmu_read_d  = 1'b0;
        mmu_write_d = 1'b0;
        mmu_addr_d  = '0;
        mmu_wdata_d = '0;
        mmu_byte_d  = 1'b0;
        if (grant_q == GNT_IF) begin
          if_rdata_d = mmu_rdata;
        end else if (mmu_read_q) begin
          mem_rdata_d = mmu_rdata;
        end
      end
      ST_DONE: begin
        grant_d   = GNT_NONE;
        uart_wr_d = 1'b0;
        if (uart_wr_q && (UART_GAP != 0)) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_ack    = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign mem_ack   = (state_q == ST_DONE) && (grant_q == GNT_MEM);
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = (mem_rd | mem_wr) & ~mem_ack;

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mmu_read  = mmu_read_q;
  assign mmu_write = mmu_write_q;
  assign mmu_addr  = mmu_addr_q;
  assign mmu_wdata = mmu_wdata_q;
  assign mmu_byte  = mmu_byte_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level timing model (grant edge, ack edge, next sample edge).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_byte;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_stall, mem_stall;
  logic        mmu_read, mmu_write;
  logic [31:0] mmu_addr, mmu_wdata;
  logic        mmu_byte;
  logic [31:0] mmu_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.UART_DATA_ADDR(MM_UART_DATA_ADDR), .UART_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte(mem_byte), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_byte(mmu_byte), .mmu_rdata(mmu_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_byte = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mmu_rdata = 32'hDEADBEEF;
    #3;
    n_checks++; if ({if_ack, mem_ack, mmu_read, mmu_write, mmu_byte} !== 5'b0)
      $display("FAIL reset_ctl got %b exp 00000", {if_ack, mem_ack, mmu_read, mmu_write, mmu_byte}); else n_pass++;
    n_checks++; if ({mmu_addr, mmu_wdata} !== 64'h0)
      $display("FAIL reset_mmu_bus got %h exp 0", {mmu_addr, mmu_wdata}); else n_pass++;
    n_checks++; if ({if_rdata, mem_rdata} !== 64'h0)
      $display("FAIL reset_rdata got %h exp 0", {if_rdata, mem_rdata}); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if ({if_ack, mem_ack, mmu_read, if_stall, mem_stall} !== 5'b0)
      $display("FAIL reset_release_idle got %b exp 00000", {if_ack, mem_ack, mmu_read, if_stall, mem_stall}); else n_pass++;
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h80000000; mmu_rdata = 32'h3C010001;
    tick();
    n_checks++; if ({mmu_read, mmu_write, mmu_byte} !== 3'b100)
      $display("FAIL ifrd_acc_ctl got %b exp 100", {mmu_read, mmu_write, mmu_byte}); else n_pass++;
    n_checks++; if (mmu_addr !== 32'h80000000 || mmu_wdata !== 32'h0)
      $display("FAIL ifrd_acc_bus got %h/%h exp 80000000/0", mmu_addr, mmu_wdata); else n_pass++;
    n_checks++; if (if_ack !== 1'b0 || if_stall !== 1'b1)
      $display("FAIL ifrd_acc_ack got ack=%b stall=%b exp 0/1", if_ack, if_stall); else n_pass++;
    tick();
    n_checks++; if (mmu_read !== 1'b0 || if_ack !== 1'b1 || if_stall !== 1'b0 || mem_ack !== 1'b0)
      $display("FAIL ifrd_done got rd=%b ack=%b stall=%b mack=%b exp 0/1/0/0", mmu_read, if_ack, if_stall, mem_ack); else n_pass++;
    n_checks++; if (if_rdata !== 32'h3C010001)
      $display("FAIL ifrd_rdata got %h exp 3c010001", if_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
    n_checks++; if (if_ack !== 1'b0)
      $display("FAIL ifrd_ack_one_cycle got %b exp 0", if_ack); else n_pass++;
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h80000100;
    mem_rd = 1'b1; mem_addr = 32'h80400010; mmu_rdata = 32'h11112222;
    tick();
    n_checks++; if (mmu_read !== 1'b1 || mmu_addr !== 32'h80400010)
      $display("FAIL prio_mem_first got rd=%b addr=%h exp 1/80400010", mmu_read, mmu_addr); else n_pass++;
    n_checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1)
      $display("FAIL prio_stalls got %b%b exp 11", if_stall, mem_stall); else n_pass++;
    tick();
    n_checks++; if (mem_ack !== 1'b1 || if_ack !== 1'b0 || if_stall !== 1'b1)
      $display("FAIL prio_mem_ack got mack=%b iack=%b istall=%b exp 1/0/1", mem_ack, if_ack, if_stall); else n_pass++;
    n_checks++; if (mem_rdata !== 32'h11112222)
      $display("FAIL prio_mem_rdata got %h exp 11112222", mem_rdata); else n_pass++;
    mem_rd = 1'b0; mmu_rdata = 32'h33334444;
    tick();
    n_checks++; if ({if_ack, mem_ack, mmu_read} !== 3'b0 || if_stall !== 1'b1)
      $display("FAIL prio_idle got %b stall=%b exp 000/1", {if_ack, mem_ack, mmu_read}, if_stall); else n_pass++;
    tick();
    n_checks++; if (mmu_read !== 1'b1 || mmu_addr !== 32'h80000100)
      $display("FAIL prio_if_grant got rd=%b addr=%h exp 1/80000100", mmu_read, mmu_addr); else n_pass++;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h33334444 || mem_rdata !== 32'h11112222)
      $display("FAIL prio_if_done got ack=%b ird=%h mrd=%h exp 1/33334444/11112222", if_ack, if_rdata, mem_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_byte_write();
    mem_wr = 1'b1; mem_byte = 1'b1; mem_addr = 32'h80400003; mem_wdata = 32'h000000AB;
    mmu_rdata = 32'h55556666;
    tick();
    n_checks++; if ({mmu_read, mmu_write, mmu_byte} !== 3'b011)
      $display("FAIL bytewr_ctl got %b exp 011", {mmu_read, mmu_write, mmu_byte}); else n_pass++;
    n_checks++; if (mmu_addr !== 32'h80400003 || mmu_wdata !== 32'h000000AB)
      $display("FAIL bytewr_bus got %h/%h exp 80400003/000000ab", mmu_addr, mmu_wdata); else n_pass++;
    tick();
    n_checks++; if ({mmu_write, mmu_byte} !== 2'b00 || mmu_wdata !== 32'h0 || mem_ack !== 1'b1)
      $display("FAIL bytewr_done got wr=%b byte=%b wd=%h ack=%b exp 0/0/0/1", mmu_write, mmu_byte, mmu_wdata, mem_ack); else n_pass++;
    n_checks++; if (mem_rdata !== 32'h11112222)
      $display("FAIL bytewr_rdata_held got %h exp 11112222", mem_rdata); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_uart_gap();
    mem_wr = 1'b1; mem_addr = MM_UART_DATA_ADDR; mem_wdata = 32'h00000041;
    if_req = 1'b1; if_addr = 32'h80000200; mmu_rdata = 32'h77778888;
    tick();
    n_checks++; if (mmu_write !== 1'b1 || mmu_addr !== MM_UART_DATA_ADDR)
      $display("FAIL uart_wr got wr=%b addr=%h exp 1/bfd003f8", mmu_write, mmu_addr); else n_pass++;
    tick();
    n_checks++; if (mem_ack !== 1'b1)
      $display("FAIL uart_ack got %b exp 1", mem_ack); else n_pass++;
    mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < GAP + 1; i++) begin
      tick();
      n_checks++; if (mmu_read !== 1'b0 || if_ack !== 1'b0 || if_stall !== 1'b1)
        $display("FAIL uart_gap_hold[%0d] got rd=%b ack=%b stall=%b exp 0/0/1", i, mmu_read, if_ack, if_stall); else n_pass++;
    end
    tick();
    n_checks++; if (mmu_read !== 1'b1 || mmu_addr !== 32'h80000200)
      $display("FAIL uart_if_grant got rd=%b addr=%h exp 1/80000200", mmu_read, mmu_addr); else n_pass++;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h77778888)
      $display("FAIL uart_if_done got ack=%b rd=%h exp 1/77778888", if_ack, if_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_acc();
    if_req = 1'b1; if_addr = 32'h80000300; mmu_rdata = 32'h9999AAAA;
    tick();
    n_checks++; if (mmu_read !== 1'b1)
      $display("FAIL rstacc_pre got %b exp 1", mmu_read); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({mmu_read, if_ack, mem_ack} !== 3'b000 || mmu_addr !== 32'h0)
      $display("FAIL rstacc_abort got %b addr=%h exp 000/0", {mmu_read, if_ack, mem_ack}, mmu_addr); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0)
      $display("FAIL rstacc_rdata got %h/%h exp 0/0", if_rdata, mem_rdata); else n_pass++;
    tick();
    n_checks++; if (if_ack !== 1'b0 || mmu_read !== 1'b0)
      $display("FAIL rstacc_no_ack got ack=%b rd=%b exp 0/0", if_ack, mmu_read); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (mmu_read !== 1'b1 || mmu_addr !== 32'h80000300)
      $display("FAIL rstacc_regrant got rd=%b addr=%h exp 1/80000300", mmu_read, mmu_addr); else n_pass++;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h9999AAAA)
      $display("FAIL rstacc_done got ack=%b rd=%h exp 1/9999aaaa", if_ack, if_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    mem_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_addr = 32'h80400000 + 32'(k * 4);
      r = $urandom;
      mmu_rdata = r;
      tick();
      n_checks++; if (mmu_read !== 1'b1 || mmu_addr !== mem_addr)
        $display("FAIL b2b_acc[%0d] got rd=%b addr=%h exp 1/%h", k, mmu_read, mmu_addr, mem_addr); else n_pass++;
      tick();
      n_checks++; if (mem_ack !== 1'b1 || mem_rdata !== r || if_ack !== 1'b0)
        $display("FAIL b2b_done[%0d] got ack=%b rd=%h iack=%b exp 1/%h/0", k, mem_ack, mem_rdata, if_ack, r); else n_pass++;
      tick();
      n_checks++; if (mem_ack !== 1'b0 || if_ack !== 1'b0 || mmu_read !== 1'b0)
        $display("FAIL b2b_idle[%0d] got ack=%b iack=%b rd=%b exp 0/0/0", k, mem_ack, if_ack, mmu_read); else n_pass++;
    end
    mem_rd = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int cyc, next_sample, acc_c, done_c;
    bit s_if, s_read, s_write, s_bsel;
    logic [31:0] s_addr, s_wdata, e_if_rdata, e_mem_rdata;
    bit mem_busy, if_busy, in_acc, e_if_ack, e_mem_ack;
    int op;

    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    cyc = 0; next_sample = 1; acc_c = -10; done_c = -10;
    s_if = 0; s_read = 0; s_write = 0; s_bsel = 0; s_addr = '0; s_wdata = '0;
    e_if_rdata = '0; e_mem_rdata = '0; mem_busy = 0; if_busy = 0;

    for (int n = 0; n < 600; n++) begin
      in_acc    = (cyc == acc_c);
      e_if_ack  = (cyc == done_c) && s_if;
      e_mem_ack = (cyc == done_c) && !s_if;
      n_checks++; if ({if_ack, mem_ack} !== {e_if_ack, e_mem_ack})
        $display("FAIL rnd_ack c%0d got %b exp %b", cyc, {if_ack, mem_ack}, {e_if_ack, e_mem_ack}); else n_pass++;
      n_checks++; if ({mmu_read, mmu_write, mmu_byte} !== {in_acc && s_read, in_acc && s_write, in_acc && s_bsel})
        $display("FAIL rnd_mmu_ctl c%0d got %b exp %b", cyc, {mmu_read, mmu_write, mmu_byte},
                 {in_acc && s_read, in_acc && s_write, in_acc && s_bsel}); else n_pass++;
      n_checks++; if (mmu_addr !== (in_acc ? s_addr : 32'h0) || mmu_wdata !== (in_acc ? s_wdata : 32'h0))
        $display("FAIL rnd_mmu_bus c%0d got %h/%h exp %h/%h", cyc, mmu_addr, mmu_wdata,
                 in_acc ? s_addr : 32'h0, in_acc ? s_wdata : 32'h0); else n_pass++;
      n_checks++; if (if_rdata !== e_if_rdata || mem_rdata !== e_mem_rdata)
        $display("FAIL rnd_rdata c%0d got %h/%h exp %h/%h", cyc, if_rdata, mem_rdata, e_if_rdata, e_mem_rdata); else n_pass++;
      n_checks++; if ({if_stall, mem_stall} !== {if_req && !e_if_ack, (mem_rd || mem_wr) && !e_mem_ack})
        $display("FAIL rnd_stall c%0d got %b exp %b", cyc, {if_stall, mem_stall},
                 {if_req && !e_if_ack, (mem_rd || mem_wr) && !e_mem_ack}); else n_pass++;

      if (e_mem_ack) begin mem_busy = 0; mem_rd = 1'b0; mem_wr = 1'b0; end
      if (!mem_busy && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 2);
        mem_rd    = (op != 1);
        mem_wr    = (op != 0);
        mem_addr  = ($urandom_range(0, 3) == 0) ? MM_UART_DATA_ADDR : $urandom;
        mem_wdata = $urandom;
        mem_byte  = 1'($urandom_range(0, 1));
        mem_busy  = 1;
      end
      if (e_if_ack) begin if_busy = 0; if_req = 1'b0; end
      if (!if_busy && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
        if_busy = 1;
      end
      mmu_rdata = $urandom;

      @(posedge clk);
      cyc++;
      if (cyc == acc_c + 1 && s_read) begin
        if (s_if) e_if_rdata = mmu_rdata;
        else      e_mem_rdata = mmu_rdata;
      end
      if (cyc == next_sample) begin
        if (mem_rd || mem_wr) begin
          s_if = 0; s_read = mem_rd; s_write = mem_wr && !mem_rd;
          s_addr = mem_addr; s_wdata = mem_wdata; s_bsel = mem_byte;
          acc_c = cyc; done_c = cyc + 1;
          next_sample = cyc + 3 + ((s_write && mem_addr == MM_UART_DATA_ADDR) ? GAP : 0);
        end else if (if_req) begin
          s_if = 1; s_read = 1; s_write = 0; s_addr = if_addr; s_wdata = '0; s_bsel = 0;
          acc_c = cyc; done_c = cyc + 1;
          next_sample = cyc + 3;
        end else begin
          next_sample = cyc + 1;
        end
      end
      #1;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    mmu_rdata = '0;
    test_reset();
    test_if_read();
    test_priority();
    test_byte_write();
    test_uart_gap();
    test_reset_mid_acc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
